// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family: controller
// state encoding, signed recoded-digit type and the step-count helper.
package booth_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    // One radix-4 Booth digit, range -2..+2.
    typedef logic signed [2:0] digit_t;

    localparam digit_t DIGIT_M2 = -3'sd2;
    localparam digit_t DIGIT_M1 = -3'sd1;
    localparam digit_t DIGIT_Z  =  3'sd0;
    localparam digit_t DIGIT_P1 =  3'sd1;
    localparam digit_t DIGIT_P2 =  3'sd2;

    // Two extension bits on the multiplier give width/2+1 radix-4 steps.
    function automatic int iter_count(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Radix-4 Booth recoder: turns the triplet {q[i+1], q[i], q[i-1]} into
// negate / select-1x / select-2x controls for the partial-product adder.
module booth_r4_recoder
    import booth_pkg::*;
(
    input  logic [2:0] triplet,
    output logic       neg,
    output logic       one,
    output logic       two
);

    digit_t digit;

    // Standard Booth table; 111 recodes to zero so no negate is requested.
    always_comb begin
        digit = DIGIT_Z;
        case (triplet)
            3'b000:  digit = DIGIT_Z;
            3'b001:  digit = DIGIT_P1;
            3'b010:  digit = DIGIT_P1;
            3'b011:  digit = DIGIT_P2;
            3'b100:  digit = DIGIT_M2;
            3'b101:  digit = DIGIT_M1;
            3'b110:  digit = DIGIT_M1;
            default: digit = DIGIT_Z;
        endcase
    end

    // Split the digit into sign and magnitude select lines.
    always_comb begin
        neg = (digit < 0);
        one = (digit == DIGIT_P1) || (digit == DIGIT_M1);
        two = (digit == DIGIT_P2) || (digit == DIGIT_M2);
    end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock.
// Operands are extended to WIDTH+2 bits so one datapath covers signed and
// unsigned multiplies; the accumulator carries one more bit to absorb +/-2M.
module booth_seq_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int ITER = iter_count(WIDTH);
    localparam int EW   = WIDTH + 2;
    localparam int AW   = WIDTH + 3;
    localparam int CW   = $clog2(ITER);

    generate
        if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("booth_seq_multiplier: WIDTH must be even and >= 4");
        end
    endgenerate

    state_t          state;
    logic [AW-1:0]   acc;
    logic [EW-1:0]   m_reg;
    logic [EW-1:0]   q_reg;
    logic            q_m1;
    logic [CW-1:0]   cnt;

    logic            neg;
    logic            one;
    logic            two;
    logic [AW-1:0]   m_ext;
    logic [AW-1:0]   addend;
    logic [AW-1:0]   sum;
    logic [AW-1:0]   acc_next;
    logic [EW-1:0]   q_next;
    logic            q_m1_next;
    logic [EW-1:0]   m_cap;
    logic [EW-1:0]   q_cap;

    booth_r4_recoder u_recoder (
        .triplet ({q_reg[1:0], q_m1}),
        .neg     (neg),
        .one     (one),
        .two     (two)
    );

    // One Booth step: add d*M to the accumulator, then shift {acc,q,q-1} right by 2.
    always_comb begin
        m_ext     = {m_reg[EW-1], m_reg};
        addend    = '0;
        if (two) begin
            addend = {m_ext[AW-2:0], 1'b0};
        end else if (one) begin
            addend = m_ext;
        end
        sum       = neg ? (acc - addend) : (acc + addend);
        acc_next  = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_next    = {sum[1:0], q_reg[EW-1:2]};
        q_m1_next = q_reg[1];
    end

    // Operand capture: sign- or zero-extend according to the requested mode.
    always_comb begin
        m_cap = signed_mode ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
        q_cap = signed_mode ? {{2{q[WIDTH-1]}}, q} : {2'b00, q};
    end

    // Controller, accumulator, counter and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        m_reg <= m_cap;
                        q_reg <= q_cap;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    q_reg <= q_next;
                    q_m1  <= q_m1_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        product <= {acc_next[WIDTH-3:0], q_next};
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status flags decode directly from the state register.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

endmodule
